dual_port_ram_bypass: RTL and testbench

Parametrised true dual-port RAM with inferred storage. Generalises the team's fixed-configuration dual-port RAM wrapper with per-byte write enables, an optional output register stage, and a selectable same-port read-during-write mode. Adds deterministic mixed-port collision forwarding, read-valid strobes, and an optional post-reset zero-clear sweep. Used as the shared scratch/buffer memory between two independent masters in the same clock domain.

---
 rtl/dual_port_ram_bypass.sv | 157 +++++++++++++++
 tb/tb_dual_port_ram_bypass.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_port_ram_bypass.sv
// True dual-port RAM with per-byte enables, cross-port write forwarding and a post-reset zero sweep.
// Read latency 1 (OUT_REG=0) or 2 (OUT_REG=1); no backpressure, one read and one write per port per cycle.
module dual_port_ram_bypass #(
  parameter int    DATA_WIDTH     = 32,
  parameter int    ADDR_WIDTH     = 10,
  parameter int    BYTE_WIDTH     = 8,
  parameter int    OUT_REG        = 0,
  parameter string RDW_SAME_PORT  = "NEW_DATA",
  parameter int    CLEAR_ON_RESET = 1
) (
  input  logic                               clock,
  input  logic                               reset,
  output logic                               init_done,
  input  logic [ADDR_WIDTH-1:0]              address_a,
  input  logic [DATA_WIDTH-1:0]              data_a,
  input  logic                               wren_a,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   byteena_a,
  input  logic                               rden_a,
  output logic [DATA_WIDTH-1:0]              q_a,
  output logic                               rvalid_a,
  input  logic [ADDR_WIDTH-1:0]              address_b,
  input  logic [DATA_WIDTH-1:0]              data_b,
  input  logic                               wren_b,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   byteena_b,
  input  logic                               rden_b,
  output logic [DATA_WIDTH-1:0]              q_b,
  output logic                               rvalid_b
);
  localparam int NB       = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH    = 1 << ADDR_WIDTH;
  localparam bit OLD_DATA = (RDW_SAME_PORT == "OLD_DATA");

  typedef enum logic {ST_CLEAR, ST_READY} state_e;
  localparam state_e RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  mem_q [DEPTH];

  logic                   ready;
  logic                   we_a, we_b, re_a, re_b;
  logic [DATA_WIDTH-1:0]  fwd_a, fwd_b, rd_a, rd_b;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == {ADDR_WIDTH{1'b1}}) state_d = ST_READY;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= RESET_STATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ready     = (state_q == ST_READY);
  assign init_done = ready;
  assign we_a      = wren_a & ready & (|byteena_a);
  assign we_b      = wren_b & ready & (|byteena_b);
  assign re_a      = rden_a & ready;
  assign re_b      = rden_b & ready;

  // Final stored word per read address: B lanes first, then A lanes so A wins a shared lane.
  always_comb begin
    fwd_a = mem_q[address_a];
    fwd_b = mem_q[address_b];
    for (int i = 0; i < NB; i++) begin
      if (we_b && byteena_b[i] && (address_b == address_a))
        fwd_a[i*BYTE_WIDTH +: BYTE_WIDTH] = data_b[i*BYTE_WIDTH +: BYTE_WIDTH];
      if (we_a && byteena_a[i])
        fwd_a[i*BYTE_WIDTH +: BYTE_WIDTH] = data_a[i*BYTE_WIDTH +: BYTE_WIDTH];
      if (we_b && byteena_b[i])
        fwd_b[i*BYTE_WIDTH +: BYTE_WIDTH] = data_b[i*BYTE_WIDTH +: BYTE_WIDTH];
      if (we_a && byteena_a[i] && (address_a == address_b))
        fwd_b[i*BYTE_WIDTH +: BYTE_WIDTH] = data_a[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  assign rd_a = (OLD_DATA && we_a) ? mem_q[address_a] : fwd_a;
  assign rd_b = (OLD_DATA && we_b) ? mem_q[address_b] : fwd_b;

  // Port A lane writes come last so they override B on a same-address, same-lane collision.
  always_ff @(posedge clock) begin
    if (state_q == ST_CLEAR) begin
      mem_q[cnt_q] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (we_b && byteena_b[i])
          mem_q[address_b][i*BYTE_WIDTH +: BYTE_WIDTH] <= data_b[i*BYTE_WIDTH +: BYTE_WIDTH];
        if (we_a && byteena_a[i])
          mem_q[address_a][i*BYTE_WIDTH +: BYTE_WIDTH] <= data_a[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  logic                  cap_vld_a, cap_vld_b;
  logic [DATA_WIDTH-1:0] cap_dat_a, cap_dat_b;

  if (OUT_REG != 0) begin : g_oreg
    logic                  s1_vld_a_q, s1_vld_b_q;
    logic [DATA_WIDTH-1:0] s1_dat_a_q, s1_dat_b_q;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        s1_vld_a_q <= 1'b0;
        s1_vld_b_q <= 1'b0;
        s1_dat_a_q <= '0;
        s1_dat_b_q <= '0;
      end else begin
        s1_vld_a_q <= re_a;
        s1_vld_b_q <= re_b;
        if (re_a) s1_dat_a_q <= rd_a;
        if (re_b) s1_dat_b_q <= rd_b;
      end
    end

    assign cap_vld_a = s1_vld_a_q;
    assign cap_vld_b = s1_vld_b_q;
    assign cap_dat_a = s1_dat_a_q;
    assign cap_dat_b = s1_dat_b_q;
  end else begin : g_noreg
    assign cap_vld_a = re_a;
    assign cap_vld_b = re_b;
    assign cap_dat_a = rd_a;
    assign cap_dat_b = rd_b;
  end

  logic                  rvalid_a_q, rvalid_b_q;
  logic [DATA_WIDTH-1:0] q_a_q, q_b_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      q_a_q      <= '0;
      q_b_q      <= '0;
    end else begin
      rvalid_a_q <= cap_vld_a;
      rvalid_b_q <= cap_vld_b;
      if (cap_vld_a) q_a_q <= cap_dat_a;
      if (cap_vld_b) q_b_q <= cap_dat_b;
    end
  end

  assign q_a      = q_a_q;
  assign q_b      = q_b_q;
  assign rvalid_a = rvalid_a_q;
  assign rvalid_b = rvalid_b_q;

endmodule

// File: tb/tb_dual_port_ram_bypass.sv
// Two instances share one stimulus stream: u0 is latency-1 NEW_DATA, u1 is latency-2 OLD_DATA.
// A word-array reference model predicts every output on every edge.
module tb_dual_port_ram_bypass;
  localparam int DW = 32, AW = 4, NB = 4, DEPTH = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [AW-1:0] address_a = '0, address_b = '0;
  logic [DW-1:0] data_a = '0, data_b = '0;
  logic          wren_a = 1'b0, wren_b = 1'b0, rden_a = 1'b0, rden_b = 1'b0;
  logic [NB-1:0] byteena_a = '0, byteena_b = '0;

  logic          init_done0, rvalid_a0, rvalid_b0, init_done1, rvalid_a1, rvalid_b1;
  logic [DW-1:0] q_a0, q_b0, q_a1, q_b1;

  dual_port_ram_bypass #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(8), .OUT_REG(0),
                         .RDW_SAME_PORT("NEW_DATA"), .CLEAR_ON_RESET(1)) u0 (
    .clock(clock), .reset(reset), .init_done(init_done0),
    .address_a(address_a), .data_a(data_a), .wren_a(wren_a), .byteena_a(byteena_a),
    .rden_a(rden_a), .q_a(q_a0), .rvalid_a(rvalid_a0),
    .address_b(address_b), .data_b(data_b), .wren_b(wren_b), .byteena_b(byteena_b),
    .rden_b(rden_b), .q_b(q_b0), .rvalid_b(rvalid_b0));

  dual_port_ram_bypass #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(8), .OUT_REG(1),
                         .RDW_SAME_PORT("OLD_DATA"), .CLEAR_ON_RESET(1)) u1 (
    .clock(clock), .reset(reset), .init_done(init_done1),
    .address_a(address_a), .data_a(data_a), .wren_a(wren_a), .byteena_a(byteena_a),
    .rden_a(rden_a), .q_a(q_a1), .rvalid_a(rvalid_a1),
    .address_b(address_b), .data_b(data_b), .wren_b(wren_b), .byteena_b(byteena_b),
    .rden_b(rden_b), .q_b(q_b1), .rvalid_b(rvalid_b1));

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [DW-1:0] mmem [DEPTH];
  int            clr_edges = 0;
  logic          mready = 1'b0;
  logic [DW-1:0] e0_qa = '0, e0_qb = '0, e1_qa = '0, e1_qb = '0, p_qa = '0, p_qb = '0;
  logic          e0_va = 1'b0, e0_vb = 1'b0, e1_va = 1'b0, e1_vb = 1'b0, p_va = 1'b0, p_vb = 1'b0;

  function automatic void chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endfunction

  // Word stored at addr once this edge's writes land (A beats B per lane).
  function automatic logic [DW-1:0] final_word(input logic [AW-1:0] addr);
    logic [DW-1:0] w;
    w = mmem[addr];
    for (int i = 0; i < NB; i++) begin
      if (wren_b && address_b == addr && byteena_b[i]) w[i*8 +: 8] = data_b[i*8 +: 8];
      if (wren_a && address_a == addr && byteena_a[i]) w[i*8 +: 8] = data_a[i*8 +: 8];
    end
    return w;
  endfunction

  task automatic model_reset();
    mready = 1'b0; clr_edges = 0;
    e0_qa = '0; e0_qb = '0; e0_va = 1'b0; e0_vb = 1'b0;
    e1_qa = '0; e1_qb = '0; e1_va = 1'b0; e1_vb = 1'b0;
    p_va = 1'b0; p_vb = 1'b0;
  endtask

  task automatic check_all();
    chk("init_done0", {31'b0, init_done0}, {31'b0, mready});
    chk("init_done1", {31'b0, init_done1}, {31'b0, mready});
    chk("rvalid_a0", {31'b0, rvalid_a0}, {31'b0, e0_va});
    chk("rvalid_b0", {31'b0, rvalid_b0}, {31'b0, e0_vb});
    chk("rvalid_a1", {31'b0, rvalid_a1}, {31'b0, e1_va});
    chk("rvalid_b1", {31'b0, rvalid_b1}, {31'b0, e1_vb});
    chk("q_a0", q_a0, e0_qa);
    chk("q_b0", q_b0, e0_qb);
    chk("q_a1", q_a1, e1_qa);
    chk("q_b1", q_b1, e1_qb);
  endtask

  // Predict the coming edge, take it, then compare #1 later.
  task automatic step();
    logic          ra, rb;
    logic [DW-1:0] na, nb, oa, ob;
    if (!reset) begin
      ra = 1'b0; rb = 1'b0; na = '0; nb = '0; oa = '0; ob = '0;
      if (!mready) begin
        mmem[clr_edges] = '0;
        clr_edges++;
        if (clr_edges == DEPTH) mready = 1'b1;
      end else begin
        ra = rden_a; rb = rden_b;
        na = final_word(address_a);
        nb = final_word(address_b);
        oa = (wren_a && byteena_a != '0) ? mmem[address_a] : na;
        ob = (wren_b && byteena_b != '0) ? mmem[address_b] : nb;
        if (wren_a) mmem[address_a] = na;
        if (wren_b) mmem[address_b] = nb;
      end
      e0_va = ra; if (ra) e0_qa = na;
      e0_vb = rb; if (rb) e0_qb = nb;
      e1_va = p_va; if (p_va) e1_qa = p_qa;
      e1_vb = p_vb; if (p_vb) e1_qb = p_qb;
      p_va = ra; p_qa = oa;
      p_vb = rb; p_qb = ob;
    end
    @(posedge clock);
    #1;
    check_all();
  endtask

  task automatic drive(input logic [AW-1:0] aa, input logic [DW-1:0] da, input logic wa,
                       input logic [NB-1:0] bea, input logic ra,
                       input logic [AW-1:0] ab, input logic [DW-1:0] db, input logic wb,
                       input logic [NB-1:0] beb, input logic rb);
    address_a = aa; data_a = da; wren_a = wa; byteena_a = bea; rden_a = ra;
    address_b = ab; data_b = db; wren_b = wb; byteena_b = beb; rden_b = rb;
  endtask

  task automatic idle();
    drive('0, '0, 1'b0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic async_reset(input string tag);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk({tag, "_init_done"}, {30'b0, init_done0, init_done1}, '0);
    chk({tag, "_rvalid"}, {28'b0, rvalid_a0, rvalid_b0, rvalid_a1, rvalid_b1}, '0);
    chk({tag, "_q_or"}, q_a0 | q_b0 | q_a1 | q_b1, '0);
  endtask

  task automatic sweep(input string tag);
    int n;
    n = 0;
    drive('0, 32'hFFFF_FFFF, 1'b1, 4'hF, 1'b1, '1, 32'hFFFF_FFFF, 1'b1, 4'hF, 1'b1);
    while (!init_done0 && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_edges"}, n, 16);
    idle();
  endtask

  typedef struct {
    logic [AW-1:0] aa; logic [DW-1:0] da; logic wa; logic [NB-1:0] bea; logic ra;
    logic [AW-1:0] ab; logic [DW-1:0] db; logic wb; logic [NB-1:0] beb; logic rb;
    logic [DW-1:0] x0a, x0b, x1a, x1b;
  } vec_t;

  vec_t vt [12];

  initial begin
    vt[0]  = '{3, 32'hAABBCCDD, 1, 4'hF, 0,  0, 0, 0, 4'h0, 0,  0, 0, 0, 0};
    vt[1]  = '{3, 32'h11223344, 1, 4'h5, 0,  0, 0, 0, 4'h0, 0,  0, 0, 0, 0};
    vt[2]  = '{3, 0, 0, 4'h0, 1,  3, 0, 0, 4'h0, 1,
               32'hAA22CC44, 32'hAA22CC44, 32'hAA22CC44, 32'hAA22CC44};
    vt[3]  = '{5, 32'hFFFFFFFF, 1, 4'hF, 1,  5, 0, 0, 4'h0, 1,
               32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF};
    vt[4]  = '{7, 32'h11111111, 1, 4'h3, 0,  7, 32'h22222222, 1, 4'hE, 0,  0, 0, 0, 0};
    vt[5]  = '{7, 0, 0, 4'h0, 1,  7, 0, 0, 4'h0, 1,
               32'h22221111, 32'h22221111, 32'h22221111, 32'h22221111};
    vt[6]  = '{7, 32'h33333333, 1, 4'h1, 0,  7, 32'h44444444, 1, 4'h9, 0,  0, 0, 0, 0};
    vt[7]  = '{7, 0, 0, 4'h0, 1,  7, 0, 0, 4'h0, 1,
               32'h44221133, 32'h44221133, 32'h44221133, 32'h44221133};
    vt[8]  = '{3, 32'h0, 1, 4'h0, 0,  3, 0, 0, 4'h0, 1,  0, 32'hAA22CC44, 0, 32'hAA22CC44};
    vt[9]  = '{15, 32'hDEADBEEF, 1, 4'hF, 0,  15, 0, 0, 4'h0, 1,  0, 32'hDEADBEEF, 0, 32'hDEADBEEF};
    vt[10] = '{15, 0, 0, 4'h0, 1,  0, 32'h12345678, 1, 4'hF, 1,
               32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 32'h0};
    vt[11] = '{0, 0, 0, 4'h0, 1,  5, 0, 0, 4'h0, 1,
               32'h12345678, 32'hFFFFFFFF, 32'h12345678, 32'hFFFFFFFF};

    // Reset state, then first sweep with traffic requested throughout
    step();
    step();
    reset = 1'b0;
    sweep("sweep0");

    for (int i = 0; i < DEPTH; i++) begin
      drive(AW'(i), 0, 0, 4'h0, 1, AW'(DEPTH-1-i), 0, 0, 4'h0, 1);
      step();
      chk("clear_word", q_a0, '0);
    end
    idle();
    step();
    step();

    for (int i = 0; i < 12; i++) begin
      drive(vt[i].aa, vt[i].da, vt[i].wa, vt[i].bea, vt[i].ra,
            vt[i].ab, vt[i].db, vt[i].wb, vt[i].beb, vt[i].rb);
      step();
      if (vt[i].ra) chk($sformatf("vec%0d_q_a0", i), q_a0, vt[i].x0a);
      if (vt[i].rb) chk($sformatf("vec%0d_q_b0", i), q_b0, vt[i].x0b);
      idle();
      step();
      if (vt[i].ra) chk($sformatf("vec%0d_q_a1", i), q_a1, vt[i].x1a);
      if (vt[i].rb) chk($sformatf("vec%0d_q_b1", i), q_b1, vt[i].x1b);
    end

    // Back-to-back reads: latency 1 vs 2, in order
    for (int i = 1; i <= 3; i++) begin
      drive(0, 0, 0, 4'h0, 0, AW'(i), 32'h101 * i, 1, 4'hF, 0);
      step();
    end
    for (int i = 1; i <= 5; i++) begin
      if (i <= 3) drive(AW'(i), 0, 0, 4'h0, 1, 0, 0, 0, 4'h0, 0);
      else idle();
      step();
      chk("lat_rv0", {31'b0, rvalid_a0}, (i <= 3) ? 32'd1 : 32'd0);
      if (i <= 3) chk("lat_q0", q_a0, 32'h101 * i);
      chk("lat_rv1", {31'b0, rvalid_a1}, (i >= 2 && i <= 4) ? 32'd1 : 32'd0);
      if (i >= 2 && i <= 4) chk("lat_q1", q_a1, 32'h101 * (i - 1));
    end

    // Reset while a read is in flight
    drive(3, 0, 0, 4'h0, 1, 5, 0, 0, 4'h0, 1);
    step();
    idle();
    async_reset("midread");
    step();
    step();
    reset = 1'b0;
    sweep("sweep1");

    // Reset in the middle of a sweep (counter = 9)
    async_reset("pre");
    step();
    reset = 1'b0;
    for (int i = 0; i < 9; i++) step();
    async_reset("midsweep");
    step();
    reset = 1'b0;
    sweep("sweep2");

    // Randomized traffic with frequent address collisions
    for (int i = 0; i < 600; i++) begin
      address_a = AW'($urandom_range(DEPTH - 1));
      address_b = ($urandom_range(2) == 0) ? address_a : AW'($urandom_range(DEPTH - 1));
      data_a = $urandom; data_b = $urandom;
      wren_a = ($urandom_range(1) == 0); wren_b = ($urandom_range(1) == 0);
      byteena_a = NB'($urandom_range(15)); byteena_b = NB'($urandom_range(15));
      rden_a = ($urandom_range(1) == 0); rden_b = ($urandom_range(1) == 0);
      step();
    end
    idle();
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
